// File: rtl/run_controller_pkg.sv
// Shared encodings for the cpu run controller: FSM states and host command opcodes.
// Host-side logic and benches import this so command codes never drift.
package run_controller_pkg;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_HALT  = 2'd1;
  localparam logic [1:0] CMD_STEP  = 2'd2;
  localparam logic [1:0] CMD_RESET = 2'd3;

  // A STEP argument of zero still executes one cycle.
  function automatic logic [7:0] step_load(input logic [7:0] arg);
    return (arg == 8'd0) ? 8'd1 : arg;
  endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the retired-cycle count.
module run_controller_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences the cpu core: clock enable, soft reset, host RUN/HALT/STEP/RESET commands
// and PC breakpoint halting.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 16,
  parameter bit          AUTO_RUN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic [15:0]      pc,
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [7:0]     step_cnt_q, step_cnt_d;
  logic           bp_skip_q, bp_skip_d;
  logic           step_done_q, step_done_d;
  logic           cpu_rst_n_q;
  logic           por_q, por_d;
  logic           cmd_acc;
  logic           bp_hit;
  logic           cnt_clr;

  assign cmd_ready = (state_q != S_RESET);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign bp_hit    = bp_en & (pc == bp_addr) & ~bp_skip_q;
  assign cpu_en    = ((state_q == S_RUN) | (state_q == S_STEP)) & ~bp_hit & ~cmd_acc;
  assign halted    = (state_q == S_HALT);
  assign step_done = step_done_q;
  assign cpu_rst_n = cpu_rst_n_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    step_cnt_d  = step_cnt_q;
    // The skip only protects the first resumed cycle; any executed cycle re-arms.
    bp_skip_d   = bp_skip_q & ~cpu_en;
    step_done_d = 1'b0;
    por_d       = por_q;
    cnt_clr     = 1'b0;

    if (cmd_acc) begin
      case (cmd_op)
        CMD_RUN:  state_d = S_RUN;
        CMD_HALT: state_d = S_HALT;
        CMD_STEP: begin
          state_d    = S_STEP;
          step_cnt_d = step_load(cmd_arg);
        end
        CMD_RESET: begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          bp_skip_d = 1'b0;
          cnt_clr   = 1'b1;
          por_d     = 1'b0;
        end
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = (AUTO_RUN && por_q) ? S_RUN : S_HALT;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (bp_hit) begin
            state_d   = S_HALT;
            bp_skip_d = 1'b1;
          end
        end
        S_STEP: begin
          if (bp_hit) begin
            state_d   = S_HALT;
            bp_skip_d = 1'b1;
          end else if (cpu_en) begin
            step_cnt_d = step_cnt_q - 8'd1;
            if (step_cnt_q == 8'd1) begin
              state_d     = S_HALT;
              step_done_d = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      step_cnt_q  <= 8'd0;
      bp_skip_q   <= 1'b0;
      step_done_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      por_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      step_cnt_q  <= step_cnt_d;
      bp_skip_q   <= bp_skip_d;
      step_done_q <= step_done_d;
      cpu_rst_n_q <= (state_d != S_RESET);
      por_q       <= por_d;
    end
  end

  run_controller_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cpu_en),
    .count(cycle_cnt)
  );

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: a looping cpu model drives pc, expectations come
// from per-scenario arithmetic over randomized step counts and breakpoint addresses.
module tb_run_controller;
  import run_controller_pkg::*;

  localparam int unsigned RC   = 4;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [7:0]    cmd_arg = 8'd0;
  logic          bp_en = 1'b0;
  logic [15:0]   bp_addr = 16'd0;
  logic [15:0]   pc = 16'd0;
  logic          cmd_ready, cpu_en, cpu_rst_n, halted, step_done;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int failures = 0;
  int en_total = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  run_controller #(
    .RST_CYCLES(RC),
    .CNT_W     (CW),
    .AUTO_RUN  (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .cpu_rst_n(cpu_rst_n),
    .halted   (halted),
    .step_done(step_done),
    .cycle_cnt(cycle_cnt)
  );

  // Toy cpu: a 64-instruction loop that advances only when enabled.
  always @(posedge clk) begin
    if (!cpu_rst_n) pc <= 16'd0;
    else if (cpu_en) pc <= (pc == 16'd63) ? 16'd0 : pc + 16'd1;
  end

  always @(posedge clk) begin
    if (cpu_en) en_total <= en_total + 1;
    if (step_done) done_total <= done_total + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_timeout: halted=%b required 1 within %0d cycles", halted, budget);
    end
  endtask

  // Counts samples with cpu_rst_n low, starting from the current sample point.
  task automatic count_lows(output int lows);
    lows = 0;
    if (!cpu_rst_n) lows++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_rst_n) break;
      lows++;
    end
  endtask

  task automatic test_reset;
    int lows;
    #1;
    checks++;
    if ({cpu_rst_n, cpu_en, cmd_ready, halted, step_done} !== 5'b0 || cycle_cnt !== '0) begin
      failures++;
      $display("FAIL reset_values: rst_n=%b en=%b rdy=%b halt=%b done=%b cnt=%0d required all 0",
               cpu_rst_n, cpu_en, cmd_ready, halted, step_done, cycle_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    count_lows(lows);
    checks++;
    if (lows != RC) begin
      failures++;
      $display("FAIL poweron_rst_len: cpu_rst_n low %0d cycles required %0d", lows, RC);
    end
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL poweron_halt: halted=%b cpu_en=%b cmd_ready=%b required 1 0 1",
               halted, cpu_en, cmd_ready);
    end
  endtask

  task automatic test_step(input int n);
    int s_en = en_total;
    int s_done = done_total;
    int s_cc = int'(cycle_cnt);
    int exp_n = (n == 0) ? 1 : n;
    int exp_cc = (s_cc + exp_n > CMAX) ? CMAX : s_cc + exp_n;
    send_cmd(CMD_STEP, 8'(n));
    wait_halted(600);
    tick();
    checks++;
    if (en_total - s_en != exp_n) begin
      failures++;
      $display("FAIL step_en_cycles arg=%0d: got %0d required %0d", n, en_total - s_en, exp_n);
    end
    checks++;
    if (done_total - s_done != 1) begin
      failures++;
      $display("FAIL step_done_pulses arg=%0d: got %0d required 1", n, done_total - s_done);
    end
    checks++;
    if (int'(cycle_cnt) != exp_cc) begin
      failures++;
      $display("FAIL step_cycle_cnt arg=%0d: got %0d required %0d", n, cycle_cnt, exp_cc);
    end
  endtask

  task automatic test_step_abort;
    int s_en = en_total;
    int s_done = done_total;
    send_cmd(CMD_STEP, 8'd50);
    repeat (5) tick();
    send_cmd(CMD_HALT, 8'd0);
    wait_halted(10);
    tick();
    checks++;
    if (en_total - s_en != 5 || done_total - s_done != 0) begin
      failures++;
      $display("FAIL step_abort: en=%0d done=%0d required 5 0", en_total - s_en,
               done_total - s_done);
    end
  endtask

  task automatic test_breakpoint;
    int b = int'($urandom_range(5, 40));
    int s_en;
    send_cmd(CMD_RESET, 8'd0);
    wait_halted(50);
    bp_addr = 16'(b);
    bp_en   = 1'b1;
    s_en    = en_total;
    send_cmd(CMD_RUN, 8'd0);
    wait_halted(200);
    checks++;
    if (pc != 16'(b) || int'(cycle_cnt) != b || en_total - s_en != b || cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_first_hit: pc=%0d cnt=%0d en=%0d cpu_en=%b required %0d %0d %0d 0",
               pc, cycle_cnt, en_total - s_en, cpu_en, b, b, b);
    end
    s_en = en_total;
    send_cmd(CMD_RUN, 8'd0);
    wait_halted(200);
    checks++;
    if (pc != 16'(b) || en_total - s_en != 64 || int'(cycle_cnt) != b + 64) begin
      failures++;
      $display("FAIL bp_rearm: pc=%0d en=%0d cnt=%0d required %0d 64 %0d",
               pc, en_total - s_en, cycle_cnt, b, b + 64);
    end
    tick();
    checks++;
    if (cpu_en !== 1'b0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: cpu_en=%b halted=%b required 0 1", cpu_en, halted);
    end
  endtask

  task automatic test_cmd_vs_bp;
    int s_en;
    logic [15:0] pc_hold;
    bp_en = 1'b0;
    send_cmd(CMD_RUN, 8'd0);
    repeat ($urandom_range(3, 10)) tick();
    bp_addr = pc;
    bp_en   = 1'b1;
    send_cmd(CMD_HALT, 8'd0);
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL cmd_over_bp_halt: halted=%b required 1", halted);
    end
    // With no skip pending, resuming at the breakpoint must stop immediately.
    pc_hold = pc;
    s_en    = en_total;
    send_cmd(CMD_RUN, 8'd0);
    repeat (3) tick();
    checks++;
    if (en_total - s_en != 0 || halted !== 1'b1 || pc != pc_hold) begin
      failures++;
      $display("FAIL cmd_over_bp_noskip: en=%0d halted=%b pc=%0d required 0 1 %0d",
               en_total - s_en, halted, pc, pc_hold);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_reset_during_step;
    int lows;
    int s_done = done_total;
    send_cmd(CMD_STEP, 8'd200);
    repeat ($urandom_range(10, 50)) tick();
    send_cmd(CMD_RESET, 8'd0);
    checks++;
    if (cmd_ready !== 1'b0 || cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL soft_reset_gate: cmd_ready=%b cpu_en=%b required 0 0", cmd_ready, cpu_en);
    end
    count_lows(lows);
    checks++;
    if (lows != RC) begin
      failures++;
      $display("FAIL soft_reset_len: cpu_rst_n low %0d cycles required %0d", lows, RC);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || cycle_cnt !== '0 || done_total - s_done != 0) begin
      failures++;
      $display("FAIL soft_reset_state: halted=%b cnt=%0d done=%0d required 1 0 0",
               halted, cycle_cnt, done_total - s_done);
    end
  endtask

  task automatic test_saturation;
    int s_en = en_total;
    int s_cc = int'(cycle_cnt);
    int exp_cc;
    send_cmd(CMD_RUN, 8'd0);
    repeat (300) tick();
    exp_cc = (s_cc + 300 > CMAX) ? CMAX : s_cc + 300;
    checks++;
    if (int'(cycle_cnt) != exp_cc || en_total - s_en != 300) begin
      failures++;
      $display("FAIL saturation: cnt=%0d en=%0d required %0d 300", cycle_cnt, en_total - s_en,
               exp_cc);
    end
    send_cmd(CMD_HALT, 8'd0);
  endtask

  task automatic test_async_reset;
    int lows;
    send_cmd(CMD_RUN, 8'd0);
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rst_n, cpu_en, cmd_ready, halted, step_done} !== 5'b0 || cycle_cnt !== '0) begin
      failures++;
      $display("FAIL async_reset: rst_n=%b en=%b rdy=%b halt=%b done=%b cnt=%0d required all 0",
               cpu_rst_n, cpu_en, cmd_ready, halted, step_done, cycle_cnt);
    end
    tick();
    rst_n = 1'b1;
    count_lows(lows);
    checks++;
    if (lows != RC || halted !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_recover: lows=%0d halted=%b required %0d 1", lows, halted, RC);
    end
  endtask

  initial begin
    test_reset();
    test_step(3);
    test_step(0);
    for (int i = 0; i < 4; i++) test_step(int'($urandom_range(1, 20)));
    test_step_abort();
    test_breakpoint();
    test_cmd_vs_bp();
    test_reset_during_step();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
